// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - HH:MM:SS run/set controller with 1 Hz prescaler
// Optional BLINK_EN: blink strobe for the selected field while in a set state.
module time_set_ctrl #(
    parameter int CLK_DIV = 50000000,
    parameter int CNT_W   = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_next,
    input  logic       key_inc,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       set_mode,
    output logic [1:0] field_sel,
    output logic       blink
);

    typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [4:0]       hour_nx;
    logic [5:0]       minute_nx, second_nx;
    logic [1:0]       field_nx;
    logic             tick;

    assign tick = (cnt == CNT_MAX);

    always_comb begin
        state_nx  = state;
        cnt_nx    = tick ? '0 : cnt + 1'b1;
        hour_nx   = hour;
        minute_nx = minute;
        second_nx = second;
        field_nx  = 2'd0;

        if (state == RUN) begin
            if (tick) begin
                second_nx = (second == 6'd59) ? 6'd0 : second + 6'd1;
                if (second == 6'd59) begin
                    minute_nx = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
                    if (minute == 6'd59)
                        hour_nx = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                end
            end
            if (key_mode)
                state_nx = SET_HH;
        end else if (key_mode) begin
            // Restart the second so the first tick after leaving set lands a full period later.
            state_nx = RUN;
            cnt_nx   = '0;
        end else if (key_next) begin
            case (state)
                SET_HH:  state_nx = SET_MM;
                SET_MM:  state_nx = SET_SS;
                default: state_nx = SET_HH;
            endcase
        end else if (key_inc) begin
            case (state)
                SET_HH:  hour_nx   = (hour == 5'd23)   ? 5'd0 : hour + 5'd1;
                SET_MM:  minute_nx = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
                default: second_nx = (second == 6'd59) ? 6'd0 : second + 6'd1;
            endcase
        end

        case (state_nx)
            SET_MM:  field_nx = 2'd1;
            SET_SS:  field_nx = 2'd2;
            default: field_nx = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= '0;
            hour      <= '0;
            minute    <= '0;
            second    <= '0;
            set_mode  <= 1'b0;
            field_sel <= 2'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            hour      <= hour_nx;
            minute    <= minute_nx;
            second    <= second_nx;
            set_mode  <= (state_nx != RUN);
            field_sel <= field_nx;
        end
    end

`ifdef BLINK_EN
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blink <= 1'b0;
        else
            blink <= (state != RUN) && (cnt < CNT_HALF);
    end
`else
    assign blink = 1'b0;
`endif

endmodule
